// File: rtl/fp_convert_issue_unit_pkg.sv
// fp_convert_issue_unit_pkg: shared fpu rounding-mode and fflags constants plus the issue FSM states
package fp_convert_issue_unit_pkg;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;
  typedef enum logic [1:0] {IDLE, CONVERT, WRITEBACK, DISCARD} state_e;
  function automatic logic rm_legal(input logic [2:0] rm);
    return rm inside {RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM};
  endfunction
  function automatic logic [4:0] conv_fflags(input logic nv, input logic nx);
    logic [4:0] f;
    f = '0;
    f[FF_NV] = nv;
    f[FF_NX] = nx;
    f[FF_DZ] = 1'b0;
    f[FF_OF] = 1'b0;
    f[FF_UF] = 1'b0;
    return f;
  endfunction
endpackage

// File: rtl/fp_convert_issue_unit.sv
// fp_convert_issue_unit: sequences one FCVT through fp_converter and holds its writeback
module fp_convert_issue_unit
  import fp_convert_issue_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_to_int,
  input  logic            req_signed,
  input  logic [2:0]      req_rm,
  input  logic [RD_W-1:0] req_rd,
  input  logic [XLEN-1:0] req_operand,
  input  logic [2:0]      frm,
  input  logic            flush,
  output logic            conv_start,
  output logic            conv_option,
  output logic            conv_signed,
  output logic [2:0]      conv_rm,
  output logic [XLEN-1:0] conv_in,
  input  logic            conv_ready,
  input  logic [XLEN-1:0] conv_out,
  input  logic            conv_nv,
  input  logic            conv_nx,
  output logic            wb_valid,
  input  logic            wb_ack,
  output logic            wb_to_fp,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal,
  output logic [4:0]      wb_fflags,
  output logic [4:0]      fflags_acc,
  input  logic            fflags_clr
);
  state_e          state_q, state_d;
  logic            pending_flush_q, pending_flush_d;
  logic            conv_option_q, conv_option_d;
  logic            conv_signed_q, conv_signed_d;
  logic [2:0]      conv_rm_q, conv_rm_d;
  logic [XLEN-1:0] conv_in_q, conv_in_d;
  logic            wb_to_fp_q, wb_to_fp_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_illegal_q, wb_illegal_d;
  logic [4:0]      wb_fflags_q, wb_fflags_d;
  logic [4:0]      fflags_acc_q, fflags_acc_d;
  logic [2:0]      rm_eff;

  always_comb begin
    rm_eff          = (req_rm == RM_DYN) ? frm : req_rm;
    state_d         = state_q;
    pending_flush_d = pending_flush_q;
    conv_option_d   = conv_option_q;
    conv_signed_d   = conv_signed_q;
    conv_rm_d       = conv_rm_q;
    conv_in_d       = conv_in_q;
    wb_to_fp_d      = wb_to_fp_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    wb_illegal_d    = wb_illegal_q;
    wb_fflags_d     = wb_fflags_q;
    // a clear lands before any same-cycle accumulate
    fflags_acc_d    = fflags_clr ? 5'd0 : fflags_acc_q;
    case (state_q)
      IDLE: if (req_valid) begin
        conv_option_d = req_to_int;
        conv_signed_d = req_signed;
        conv_rm_d     = rm_eff;
        conv_in_d     = req_operand;
        wb_to_fp_d    = ~req_to_int;
        wb_rd_d       = req_rd;
        wb_data_d     = '0;
        wb_fflags_d   = '0;
        wb_illegal_d  = ~rm_legal(rm_eff);
        state_d       = rm_legal(rm_eff) ? CONVERT : WRITEBACK;
      end
      CONVERT: if (conv_ready) begin
        wb_data_d   = (flush | pending_flush_q) ? wb_data_q : conv_out;
        wb_fflags_d = (flush | pending_flush_q) ? wb_fflags_q : conv_fflags(conv_nv, conv_nx);
        state_d     = (flush | pending_flush_q) ? DISCARD : WRITEBACK;
      end else if (flush) begin
        pending_flush_d = 1'b1;
      end
      WRITEBACK: if (flush) begin
        state_d = IDLE;
      end else if (wb_ack) begin
        fflags_acc_d = fflags_acc_d | wb_fflags_q;
        state_d      = IDLE;
      end
      default: begin
        pending_flush_d = 1'b0;
        state_d         = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pending_flush_q <= 1'b0;
      conv_option_q   <= 1'b0;
      conv_signed_q   <= 1'b0;
      conv_rm_q       <= '0;
      conv_in_q       <= '0;
      wb_to_fp_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      wb_illegal_q    <= 1'b0;
      wb_fflags_q     <= '0;
      fflags_acc_q    <= '0;
    end else begin
      state_q         <= state_d;
      pending_flush_q <= pending_flush_d;
      conv_option_q   <= conv_option_d;
      conv_signed_q   <= conv_signed_d;
      conv_rm_q       <= conv_rm_d;
      conv_in_q       <= conv_in_d;
      wb_to_fp_q      <= wb_to_fp_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      wb_illegal_q    <= wb_illegal_d;
      wb_fflags_q     <= wb_fflags_d;
      fflags_acc_q    <= fflags_acc_d;
    end
  end

  assign req_ready   = state_q == IDLE;
  assign conv_start  = state_q == CONVERT;
  assign wb_valid    = state_q == WRITEBACK;
  assign conv_option = conv_option_q;
  assign conv_signed = conv_signed_q;
  assign conv_rm     = conv_rm_q;
  assign conv_in     = conv_in_q;
  assign wb_to_fp    = wb_to_fp_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_illegal  = wb_illegal_q;
  assign wb_fflags   = wb_fflags_q;
  assign fflags_acc  = fflags_acc_q;
endmodule

// File: tb/tb_fp_convert_issue_unit.sv
// tb_fp_convert_issue_unit: random FCVT traffic against a behavioural converter and issue model
module tb_fp_convert_issue_unit;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_to_int, req_signed, flush;
  logic [2:0]  req_rm, frm, conv_rm;
  logic [4:0]  req_rd, wb_rd, wb_fflags, fflags_acc;
  logic [31:0] req_operand, conv_in, conv_out, wb_data;
  logic        conv_start, conv_option, conv_signed, conv_ready, conv_nv, conv_nx;
  logic        wb_valid, wb_ack, wb_to_fp, wb_illegal, fflags_clr;
  int          checks = 0, failures = 0;
  logic [4:0]  acc_m = 5'd0;
  logic        cv_busy;
  int          cv_cnt, cv_d;
  logic [36:0] cv_ops;

  always #5 clk = ~clk;

  fp_convert_issue_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_to_int(req_to_int), .req_signed(req_signed), .req_rm(req_rm), .req_rd(req_rd),
    .req_operand(req_operand), .frm(frm), .flush(flush), .conv_start(conv_start),
    .conv_option(conv_option), .conv_signed(conv_signed), .conv_rm(conv_rm), .conv_in(conv_in),
    .conv_ready(conv_ready), .conv_out(conv_out), .conv_nv(conv_nv), .conv_nx(conv_nx),
    .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_to_fp(wb_to_fp), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_illegal(wb_illegal), .wb_fflags(wb_fflags),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rinc(input logic [2:0] rm, input logic neg, input logic lsb,
                                input logic [63:0] rem, input logic [63:0] half);
    case (rm)
      3'd0: return rem > half || (rem == half && lsb);
      3'd2: return neg && rem != 0;
      3'd3: return !neg && rem != 0;
      3'd4: return rem >= half;
      default: return 1'b0;
    endcase
  endfunction

  // returns {nv, nx, result}
  function automatic logic [33:0] ref_f2i(input logic [31:0] a, input logic s, input logic [2:0] rm);
    logic neg = a[31];
    int e = int'(a[30:23]);
    logic [63:0] m, ip, rem, half, mag;
    if (e == 255) begin
      if (s) return {2'b10, (neg && a[22:0] == 0) ? 32'h8000_0000 : 32'h7fff_ffff};
      return {2'b10, (neg && a[22:0] == 0) ? 32'h0 : 32'hffff_ffff};
    end
    m = {40'd0, e != 0, a[22:0]};
    if (e == 0) e = 1;
    if (e >= 150) begin
      ip = (e - 150 > 40) ? 64'd1 << 40 : m << (e - 150); rem = 0; half = 1;
    end else if (150 - e > 30) begin
      ip = 0; rem = {63'd0, m != 0}; half = 64'd1 << 40;
    end else begin
      ip = m >> (150 - e); rem = m & ((64'd1 << (150 - e)) - 1); half = 64'd1 << (149 - e);
    end
    mag = ip + {63'd0, rinc(rm, neg, ip[0], rem, half)};
    if (s && (neg ? mag > 64'h8000_0000 : mag > 64'h7fff_ffff))
      return {2'b10, neg ? 32'h8000_0000 : 32'h7fff_ffff};
    if (!s && neg && mag != 0) return {2'b10, 32'h0};
    if (!s && !neg && mag > 64'hffff_ffff) return {2'b10, 32'hffff_ffff};
    return {1'b0, rem != 0, neg ? -mag[31:0] : mag[31:0]};
  endfunction

  function automatic logic [33:0] ref_i2f(input logic [31:0] a, input logic s, input logic [2:0] rm);
    logic neg = s & a[31];
    logic [31:0] mag = neg ? -a : a;
    int p = 0, ex;
    logic [63:0] ip, rem, half;
    if (mag == 0) return 34'd0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    ex = 127 + p;
    if (p <= 23) begin
      ip = {32'd0, mag} << (23 - p); rem = 0; half = 1;
    end else begin
      ip = {32'd0, mag >> (p - 23)}; rem = {32'd0, mag} & ((64'd1 << (p - 23)) - 1); half = 64'd1 << (p - 24);
    end
    ip = ip + {63'd0, rinc(rm, neg, ip[0], rem, half)};
    if (ip[24]) begin ip = ip >> 1; ex++; end
    return {1'b0, rem != 0, neg, ex[7:0], ip[22:0]};
  endfunction

  // behavioural fp_converter: result after a variable delay, held until start falls
  initial begin
    conv_ready = 0; conv_out = 0; conv_nv = 0; conv_nx = 0; cv_busy = 0; cv_cnt = 0; cv_d = 0; cv_ops = 0;
    forever begin
      @(negedge clk);
      if (rst || !conv_start) begin
        conv_ready = 0; cv_busy = 0;
      end else if (!cv_busy) begin
        cv_busy = 1;
        cv_d = conv_option ? 0 : int'($urandom_range(5, 2));
        cv_cnt = cv_d;
        cv_ops = {conv_option, conv_signed, conv_rm, conv_in};
      end else begin
        chk("conv_operands_stable", {conv_option, conv_signed, conv_rm, conv_in}, cv_ops);
        if (cv_cnt > 0) cv_cnt--;
        else if (!conv_ready) begin
          {conv_nv, conv_nx, conv_out} = cv_ops[36] ? ref_f2i(cv_ops[31:0], cv_ops[35], cv_ops[34:32])
                                                    : ref_i2f(cv_ops[31:0], cv_ops[35], cv_ops[34:32]);
          conv_ready = 1;
        end
      end
    end
  end

  task automatic run_op(input logic ti, input logic sg, input logic [2:0] rm, input logic [2:0] fr,
                        input logic [4:0] rd, input logic [31:0] op, input int hold,
                        input logic clr, input logic drop);
    logic [2:0]  rme = (rm == 3'b111) ? fr : rm;
    logic        ill = rme > 3'b100;
    logic [33:0] r = ill ? 34'd0 : ti ? ref_f2i(op, sg, rme) : ref_i2f(op, sg, rme);
    logic        seen = 0;
    int          n = 0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_to_int = ti; req_signed = sg; req_rm = rm; frm = fr; req_rd = rd; req_operand = op;
    @(negedge clk);
    req_valid = 0; frm = 3'($urandom); req_operand = $urandom;
    while (!wb_valid && n < 20) begin
      seen |= conv_start;
      @(negedge clk);
      n++;
    end
    chk("wb_valid", wb_valid, 1);
    if (ill) chk("illegal_no_start", seen, 0);
    if (ti && !ill) chk("f2i_latency", n, 2);
    chk("wb_to_fp", wb_to_fp, !ti);
    chk("wb_rd", wb_rd, rd);
    chk("wb_data", wb_data, r[31:0]);
    chk("wb_illegal", wb_illegal, ill);
    chk("wb_fflags", wb_fflags, {r[33], 3'b000, r[32]});
    chk("wb_start_low", conv_start, 0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_rd = 5'($urandom);
      @(negedge clk);
      chk("hold_valid", wb_valid, 1);
      chk("hold_data", wb_data, r[31:0]);
      chk("hold_rd", wb_rd, rd);
      chk("hold_not_ready", req_ready, 0);
    end
    req_valid = 0;
    if (drop) flush = 1; else wb_ack = 1;
    fflags_clr = clr;
    @(negedge clk);
    flush = 0; wb_ack = 0; fflags_clr = 0;
    acc_m = clr ? 5'd0 : acc_m;
    if (!drop) acc_m |= {r[33], 3'b000, r[32]};
    chk("fflags_acc", fflags_acc, acc_m);
    chk("after_ack_idle", {wb_valid, req_ready}, 2'b01);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_conv", {conv_start, conv_option, conv_signed, conv_rm, conv_in}, 0);
    chk("rst_wb", {wb_valid, wb_to_fp, wb_rd, wb_data, wb_illegal, wb_fflags}, 0);
    chk("rst_acc", fflags_acc, 0);
    chk("rst_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] op;
    logic [4:0]  acc_save;
    int          ns, n;
    logic        wbv;
    rst = 1; req_valid = 0; req_to_int = 0; req_signed = 0; req_rm = 0; req_rd = 0; req_operand = 0;
    frm = 0; flush = 0; wb_ack = 0; fflags_clr = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 0;
    @(negedge clk);
    run_op(0, 1, 3'b000, 3'b000, 5'd1, 32'd3, 0, 0, 0);
    chk("tp1_data", wb_data, 32'h4040_0000);
    run_op(1, 1, 3'b000, 3'b000, 5'd2, 32'h3FC0_0000, 0, 0, 0);
    chk("tp2_data", wb_data, 32'd2);
    chk("tp2_acc", fflags_acc, 5'b00001);
    run_op(1, 0, 3'b000, 3'b000, 5'd3, 32'hBF80_0000, 0, 0, 0);
    chk("tp3_flags", wb_fflags, 5'b10000);
    run_op(1, 1, 3'b111, 3'b001, 5'd4, 32'h4020_0000, 0, 0, 0);
    chk("tp4_data", wb_data, 32'd2);
    run_op(1, 1, 3'b111, 3'b101, 5'd5, 32'h4020_0000, 0, 0, 0);
    chk("tp4_illegal", {wb_illegal, wb_data}, {1'b1, 32'd0});
    run_op(0, 0, 3'b010, 3'b000, 5'd6, 32'hFFFF_FFFF, 3, 0, 0);
    // flush one cycle after accepting an int->fp op
    acc_save = fflags_acc;
    req_valid = 1; req_to_int = 0; req_signed = 1; req_rm = 3'b000; req_rd = 5'd7; req_operand = 32'h0001_0000;
    @(negedge clk);
    req_valid = 0;
    ns = int'(conv_start); wbv = wb_valid;
    flush = 1;
    @(negedge clk);
    flush = 0; n = 0;
    while (!req_ready && n < 20) begin
      ns += int'(conv_start); wbv |= wb_valid;
      @(negedge clk);
      n++;
    end
    chk("flush_idle", req_ready, 1);
    chk("flush_start_held", ns, cv_d + 2);
    chk("flush_no_wb", wbv, 0);
    chk("flush_acc", fflags_acc, acc_save);
    // reset mid-CONVERT
    req_valid = 1; req_to_int = 0; req_signed = 0; req_rm = 3'b011; req_rd = 5'd9; req_operand = 32'h1234_5678;
    @(negedge clk);
    req_valid = 0;
    chk("pre_rst_convert", conv_start, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_outputs();
    acc_m = 5'd0;
    @(negedge clk);
    for (int k = 0; k < 60; k++) begin
      logic ti = 1'($urandom);
      if (ti && $urandom_range(0, 4) != 0)
        op = {1'($urandom), 8'($urandom_range(110, 165)), 23'($urandom)};
      else if (!ti && $urandom_range(0, 2) == 0)
        op = $urandom_range(0, 300);
      else
        op = $urandom;
      run_op(ti, 1'($urandom), 3'($urandom), 3'($urandom), 5'($urandom), op,
             $urandom_range(0, 2), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_convert_issue_unit.md
Name: fp_convert_issue_unit

Overview:
- Sequencing stage directly upstream of fp_converter.
- Accepts one decoded FCVT request (FCVT.W.S, FCVT.WU.S, FCVT.S.W, FCVT.S.WU) from the FPU dispatch.
- Resolves the rounding mode, drives the converter's start-level handshake, captures its result and flags, and presents a held writeback to the register-file / CSR stage.
- Also keeps the sticky fflags accumulator for conversions.

Parameters:
XLEN, 32, operand and result width; must be 32 to match fp_converter.
RD_W, 5, destination register index width.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  dispatch offers a conversion.
req_ready  out  1  high only in IDLE; transfer occurs when req_valid & req_ready.
req_to_int  in  1  1: fp→int (converter option=1); 0: int→fp.
req_signed  in  1  integer side is signed (W) versus unsigned (WU).
req_rm  in  3  instruction rm field; 3'b111 = dynamic.
req_rd  in  RD_W  destination register.
req_operand  in  XLEN  source value, fp bits or integer.
frm  in  3  fcsr.frm, sampled at acceptance only.
flush  in  1  discard the in-flight op; no writeback.
conv_start  out  1  to fp_converter.start.
conv_option  out  1  to fp_converter.option.
conv_signed  out  1  to fp_converter.integer_is_signed.
conv_rm  out  3  to fp_converter.rm.
conv_in  out  XLEN  to fp_converter.in.
conv_ready  in  1  from fp_converter.ready.
conv_out  in  XLEN  from fp_converter.out.
conv_nv  in  1  from fp_converter.NV.
conv_nx  in  1  from fp_converter.NX.
wb_valid  out  1  result held for writeback.
wb_ack  in  1  consumer takes the result.
wb_to_fp  out  1  1: write f-register; 0: write x-register.
wb_rd  out  RD_W  destination.
wb_data  out  XLEN  result.
wb_illegal  out  1  request had an illegal rounding mode.
wb_fflags  out  5  {NV,DZ,OF,UF,NX} for this op.
fflags_acc  out  5  sticky OR of all written-back wb_fflags.
fflags_clr  in  1  clears fflags_acc (CSR write path).

Behaviour:
- Reset: state=IDLE; all operand and result registers, wb_* outputs, conv_start and fflags_acc are 0.
- Reset mid-operation aborts immediately. fp_converter shares rst, so both return to idle together.
- Conv_* operand outputs are registered and stay stable from acceptance until leaving CONVERT.
- Rounding-mode resolution at acceptance: rm_eff = (req_rm==3'b111) ? frm : req_rm. rm_eff in 3'b000..3'b100 is legal; 101/110 are illegal.
- FSM states: IDLE, CONVERT, WRITEBACK, DISCARD.
  - IDLE: req_ready=1. On accept, latch the operands, rd, wb_to_fp=~req_to_int and rm_eff.
    - Illegal rm_eff: go to WRITEBACK with wb_illegal=1, wb_data=0, wb_fflags=0. The converter is not started.
    - Legal rm_eff: go to CONVERT.
  - CONVERT: conv_start=1.
    - If conv_ready=1 and neither flush nor pending_flush is set: capture conv_out into wb_data and wb_fflags={conv_nv,0,0,0,conv_nx}, then go to WRITEBACK.
    - If conv_ready=1 and (flush | pending_flush): go to DISCARD.
    - If flush=1 while conv_ready=0: set pending_flush and keep conv_start=1 until conv_ready. fp_converter int→fp cannot abort mid-iteration.
  - WRITEBACK: conv_start=0 and wb_valid=1; outputs are held until wb_ack.
    - On wb_ack: fflags_acc |= wb_fflags, then go to IDLE.
    - flush in WRITEBACK drops the result: go to IDLE without updating fflags_acc.
  - DISCARD: conv_start=0 for one cycle, clear pending_flush, go to IDLE.
- conv_start is low for at least one cycle between operations, so the fp_converter final state returns to waiting.
- Latency, accept to wb_valid:
  - fp→int and trivial (exception) cases: 2 cycles.
  - int→fp: 2 cycles plus the converter's normalise/round iterations.
- If fflags_clr and an accumulate happen in the same cycle, fflags_acc = wb_fflags (clear first, then OR).
- DZ, OF and UF are always 0 for conversions.

Decomposition:
- Shared fpu package: rounding-mode constants (RNE=000 … RMM=100, DYN=111), the fflags bit-index constants, and the FSM state enum.
- No sub-module. A single module of about 150–200 lines containing the FSM, operand/result registers and the fflags accumulator.

Test Plan:
1. int→fp: to_int=0, signed=1, operand 32'd3, rm=000 → wb_data 0x40400000, wb_to_fp=1, wb_fflags=0.
2. fp→int: to_int=1, signed=1, operand 0x3FC00000 (1.5), rm=000 → wb_data 2, wb_fflags=5'b00001; fflags_acc=00001 after ack.
3. fp→int: to_int=1, signed=0 (WU), operand 0xBF800000 (-1.0) → wb_data 0, NV set (wb_fflags=10000).
4. Dynamic rm: req_rm=111, frm=001, 0x40200000 (2.5) → 2 with NX. Then req_rm=111, frm=101 → wb_illegal=1, conv_start never asserted.
5. Backpressure: hold wb_ack=0 for 3 cycles → wb_valid, wb_data and wb_rd stable; req_ready=0; a req_valid presented meanwhile is not accepted.
6. Abort cases:
   - flush one cycle after accepting an int→fp op (operand 0x00010000) → conv_start held until conv_ready, no wb_valid, fflags_acc unchanged, back in IDLE.
   - rst asserted mid-CONVERT → next cycle all outputs 0, req_ready=1.
